// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default data-memory size.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned LSU_MEM_BYTES = 128;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; master is the surrounding system.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/lsu_align.sv
// Big-endian lane selection for loads (with sign/zero extension) and lane
// merge of byte/halfword store data into a previously read memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] ext_s;

  always_comb begin
    // Offset 0 is the most significant byte of the word.
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
    byte_s   = signed'(byte_sel);
    half_s   = signed'(half_sel);

    ext_s     = 32'sd0;
    load_data = rdata;
    case (size)
      SZ_B: begin
        ext_s = byte_s;
        if (is_unsigned) load_data = {24'h0, byte_sel};
        else             load_data = ext_s;
      end
      SZ_H: begin
        ext_s = half_s;
        if (is_unsigned) load_data = {16'h0, half_sel};
        else             load_data = ext_s;
      end
      default: load_data = rdata;
    endcase

    merged = rdata;
    case (size)
      SZ_B: begin
        case (offset)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (offset[1]) merged[15:0]  = wdata;
        else           merged[31:16] = wdata;
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates each access, performs word
// reads/writes (read-modify-write for sub-word stores) and returns one response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_bad;
  logic [31:0] req_base;
  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_align u_align (
    .rdata       (bus.mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    req_base = {bus.req_addr[31:2], 2'b00};
    case (bus.req_size)
      SZ_B:    req_bad = 1'b0;
      SZ_H:    req_bad = bus.req_addr[0];
      SZ_W:    req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if (req_base > LAST_WORD) req_bad = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = 32'h0;
    mem_wdata_d  = 32'h0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata[15:0];
          if (req_bad) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_write && bus.req_size == SZ_W) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = req_base;
            mem_wdata_d = bus.req_wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d    = READ;
            mem_read_d = 1'b1;
            mem_addr_d = req_base;
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (write_q) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = {addr_q[31:2], 2'b00};
          mem_wdata_d = merged;
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_B;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 16'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-array reference model predicts
// every response and memory strobe, checked cycle by cycle.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MB = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int pcnt = 0;
  int tot_resp = 0;
  bit chk_en = 1'b0;

  typedef struct {int at; int acc; logic [31:0] rdata; logic err;} resp_t;
  typedef struct {int at; logic wr; logic [31:0] addr; logic [31:0] wdata;} strb_t;
  resp_t rq[$];
  strb_t sq[$];

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  logic [31:0] last_wa, last_wd;

  logic [31:0] phys [0:31];
  logic [7:0]  refm [0:127];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s bound expired", name);
  endfunction

  always @(posedge clk) pcnt <= pcnt + 1;

  // Word-organised memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_read)
      bus.mem_rdata <= (bus.mem_addr < 32'(MB)) ? phys[bus.mem_addr[6:2]] : 32'hDEADBEEF;
    if (bus.mem_write) begin
      last_wa <= bus.mem_addr;
      last_wd <= bus.mem_wdata;
      if (bus.mem_addr < 32'(MB)) phys[bus.mem_addr[6:2]] <= bus.mem_wdata;
    end
  end

  always @(negedge clk) if (bus.resp_valid) tot_resp++;

  function automatic logic [31:0] be_word(int b);
    return {refm[b], refm[b+1], refm[b+2], refm[b+3]};
  endfunction

  // Predict response and strobes of one access accepted at the edge after
  // cycle count acc; the memory image is updated at acceptance.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input int acc);
    logic [31:0] base;
    int i;
    bit bad;
    resp_t r;
    base = {a[31:2], 2'b00};
    i = int'(a[6:0]);
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || (base > 32'(MB - 4));
    r.acc = acc;
    r.err = bad;
    r.rdata = 32'h0;
    if (bad) begin
      r.at = acc + 1;
    end else if (!wr) begin
      sq.push_back('{at: acc + 1, wr: 1'b0, addr: base, wdata: 32'h0});
      case (sz)
        2'b00:   r.rdata = uns ? {24'h0, refm[i]} : {{24{refm[i][7]}}, refm[i]};
        2'b01:   r.rdata = uns ? {16'h0, refm[i], refm[i+1]}
                               : {{16{refm[i][7]}}, refm[i], refm[i+1]};
        default: r.rdata = be_word(i);
      endcase
      r.at = acc + 3;
    end else if (sz == 2'b10) begin
      for (int k = 0; k < 4; k++) refm[i+k] = wd[31-8*k -: 8];
      sq.push_back('{at: acc + 1, wr: 1'b1, addr: base, wdata: wd});
      r.at = acc + 2;
    end else begin
      sq.push_back('{at: acc + 1, wr: 1'b0, addr: base, wdata: 32'h0});
      if (sz == 2'b00) refm[i] = wd[7:0];
      else begin
        refm[i]   = wd[15:8];
        refm[i+1] = wd[7:0];
      end
      sq.push_back('{at: acc + 3, wr: 1'b1, addr: base, wdata: be_word(int'(base[6:0]))});
      r.at = acc + 4;
    end
    rq.push_back(r);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (rq.size() > 0 && rq[0].at == pcnt) begin
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        if (bus.resp_valid) begin
          check("resp_rdata", bus.resp_rdata, rq[0].rdata);
          check("resp_err", 32'(bus.resp_err), 32'(rq[0].err));
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
          last_lat   = pcnt - rq[0].acc;
        end
        void'(rq.pop_front());
      end else begin
        check("resp_valid_quiet", 32'(bus.resp_valid), 32'd0);
      end
      if (sq.size() > 0 && sq[0].at == pcnt) begin
        check("mem_read", 32'(bus.mem_read), 32'(!sq[0].wr));
        check("mem_write", 32'(bus.mem_write), 32'(sq[0].wr));
        check("mem_addr", bus.mem_addr, sq[0].addr);
        check("mem_wdata", bus.mem_wdata, sq[0].wdata);
        void'(sq.pop_front());
      end else begin
        check("strobes_quiet", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check("mem_addr_quiet", bus.mem_addr, 32'h0);
        check("mem_wdata_quiet", bus.mem_wdata, 32'h0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    while (!bus.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      fail_now("req_ready_wait");
      bus.req_valid = 1'b0;
      return;
    end
    model(wr, sz, uns, a, wd, pcnt);
    @(negedge clk);
  endtask

  task automatic idle();
    int n = 0;
    bus.req_valid = 1'b0;
    while ((rq.size() != 0 || sq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || sq.size() != 0) begin
      fail_now("resp_wait");
      rq.delete();
      sq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int tot0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    for (int w = 0; w < 32; w++) phys[w] = (32'(w) * 32'h01010101) ^ 32'h5A3C0F00;
    phys[4]  = 32'h8899AABB;
    phys[12] = 32'h11223344;
    for (int w = 0; w < 32; w++)
      for (int k = 0; k < 4; k++) refm[4*w+k] = phys[w][31-8*k -: 8];

    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp", {29'h0, bus.resp_valid, bus.resp_err, bus.mem_read}, 32'h0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);

    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    do_req(1'b0, SZ_B, 1'b0, 32'h11, 32'h0); idle();
    check("lb_0x11", last_rdata, 32'hFFFFFF99);
    check("lb_lat", 32'(last_lat), 32'd3);
    check("lb_err", 32'(last_err), 32'd0);
    do_req(1'b0, SZ_B, 1'b1, 32'h13, 32'h0); idle();
    check("lbu_0x13", last_rdata, 32'h000000BB);
    do_req(1'b0, SZ_H, 1'b0, 32'h12, 32'h0); idle();
    check("lh_0x12", last_rdata, 32'hFFFFAABB);
    do_req(1'b0, SZ_H, 1'b1, 32'h10, 32'h0); idle();
    check("lhu_0x10", last_rdata, 32'h00008899);

    do_req(1'b1, SZ_H, 1'b0, 32'h12, 32'h00001234); idle();
    check("sh_wdata", last_wd, 32'h88991234);
    check("sh_waddr", last_wa, 32'h10);
    check("sh_lat", 32'(last_lat), 32'd4);
    do_req(1'b1, SZ_B, 1'b0, 32'h11, 32'hABCDEFEE); idle();
    do_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0); idle();
    check("lw_after_sb", last_rdata, 32'h88EE1234);

    do_req(1'b0, SZ_W, 1'b0, 32'h06, 32'h0); idle();
    check("err_lw06", 32'(last_err), 32'd1);
    check("err_lat", 32'(last_lat), 32'd1);
    check("err_rdata", last_rdata, 32'h0);
    do_req(1'b0, SZ_H, 1'b0, 32'h11, 32'h0); idle();
    check("err_lh11", 32'(last_err), 32'd1);
    do_req(1'b0, SZ_W, 1'b0, 32'h80, 32'h0); idle();
    check("err_lw80", 32'(last_err), 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h55); idle();
    do_req(1'b0, SZ_W, 1'b0, 32'h7C, 32'h0); idle();
    check("lw_7c_ok", 32'(last_err), 32'd0);
    do_req(1'b0, SZ_B, 1'b1, 32'h7F, 32'h0); idle();
    do_req(1'b1, SZ_B, 1'b0, 32'h80, 32'h0); idle();

    do_req(1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFEF00D);
    do_req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    idle();
    check("b2b_lw", last_rdata, 32'hCAFEF00D);

    chk_en = 1'b0;
    tot0 = tot_resp;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h31;
    bus.req_wdata    = 32'h77;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_write", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_write_drop", 32'(bus.mem_write), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_quiet", {30'h0, bus.resp_valid, bus.mem_read}, 32'h0);
    check("rst_mid_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_resp", 32'(tot_resp - tot0), 32'd0);
    check("rst_mem_kept", phys[12], 32'h11223344);
    chk_en = 1'b1;
    do_req(1'b0, SZ_W, 1'b0, 32'h30, 32'h0); idle();
    check("lw_after_rst", last_rdata, 32'h11223344);

    for (int w = 0; w < 32; w++) check("mem_image", phys[w], be_word(4 * w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
